// File: rtl/frame_drain_reader_if.sv
// Read-side (producer -> block) and downstream (block -> sink) valid/ready bundle.
// The slave view belongs to the drain reader; the master view drives it from outside.
interface frame_drain_reader_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] rd_data_i;
  logic             rd_valid_i;
  logic             rd_ready_o;
  logic [WIDTH-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_last_o;
  logic             m_ready_i;

  modport slave (
    input  rd_data_i, rd_valid_i, m_ready_i,
    output rd_ready_o, m_data_o, m_valid_o, m_last_o
  );

  modport master (
    output rd_data_i, rd_valid_i, m_ready_i,
    input  rd_ready_o, m_data_o, m_valid_o, m_last_o
  );
endinterface

// File: rtl/frame_drain_reader.sv
// Drains one DEPTH-sample frame per buffer_ready pulse through a single output register, with frame sum/peak.
// Accept n -> m_valid n+1; last downstream handshake k -> frame_done k+1; rd_ready drops while the output is stalled.
module frame_drain_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ACC_WIDTH  = WIDTH + ADDR_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        buffer_ready_i,
  input  logic                        buffer_overflow_i,
  frame_drain_reader_if.slave         bus,
  output logic signed [ACC_WIDTH-1:0] frame_sum_o,
  output logic [WIDTH-1:0]            frame_peak_o,
  output logic                        frame_done_o,
  output logic [15:0]                 frame_count_o,
  output logic                        overrun_o,
  output logic                        overflow_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [ADDR_WIDTH-1:0]         r_count;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]              r_peak;
  logic [WIDTH-1:0]              r_m_data;
  logic                          r_m_valid;
  logic                          r_m_last;
  logic signed [ACC_WIDTH-1:0]   r_frame_sum;
  logic [WIDTH-1:0]              r_frame_peak;
  logic [15:0]                   r_frame_count;
  logic                          r_overrun;
  logic                          r_overflow;

  logic                          w_rd_ready;
  logic                          w_accept;
  logic                          w_m_hs;
  logic                          w_frame_start;
  logic                          w_done_entry;
  logic [WIDTH-1:0]              w_abs;
  logic signed [ACC_WIDTH-1:0]   w_sample_ext;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (buffer_ready_i) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_rd_ready = !r_m_valid || bus.m_ready_i;
        if (w_rd_ready && bus.rd_valid_i && (r_count == LAST_IDX)) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!r_m_valid || bus.m_ready_i) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = buffer_ready_i ? DRAIN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept      = w_rd_ready && bus.rd_valid_i;
  assign w_m_hs        = r_m_valid && bus.m_ready_i;
  assign w_frame_start = (w_state_nxt == DRAIN) && (r_state != DRAIN);
  assign w_done_entry  = (w_state_nxt == DONE) && (r_state != DONE);
  // Two's-complement negate of the most negative value yields 2^(WIDTH-1), exact as unsigned.
  assign w_abs         = bus.rd_data_i[WIDTH-1] ? (~bus.rd_data_i + WIDTH'(1)) : bus.rd_data_i;
  assign w_sample_ext  = ACC_WIDTH'($signed(bus.rd_data_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_acc         <= '0;
      r_peak        <= '0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_frame_sum   <= '0;
      r_frame_peak  <= '0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_frame_start) begin
        r_count <= '0;
        r_acc   <= '0;
        r_peak  <= '0;
      end else if (w_accept) begin
        r_count <= r_count + 1'b1;
        r_acc   <= r_acc + w_sample_ext;
        if (w_abs > r_peak) r_peak <= w_abs;
      end

      if (w_accept) begin
        r_m_data  <= bus.rd_data_i;
        r_m_valid <= 1'b1;
        r_m_last  <= (r_count == LAST_IDX);
      end else if (w_m_hs) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end

      if (w_done_entry) begin
        r_frame_sum   <= r_acc;
        r_frame_peak  <= r_peak;
        r_frame_count <= r_frame_count + 16'd1;
      end

      // A start request mid-frame is flagged and dropped, never queued.
      if (buffer_ready_i && ((r_state == DRAIN) || (r_state == FLUSH))) r_overrun <= 1'b1;
      if (buffer_overflow_i) r_overflow <= 1'b1;
    end
  end

  assign bus.rd_ready_o = w_rd_ready;
  assign bus.m_data_o   = r_m_data;
  assign bus.m_valid_o  = r_m_valid;
  assign bus.m_last_o   = r_m_last;
  assign frame_sum_o    = r_frame_sum;
  assign frame_peak_o   = r_frame_peak;
  assign frame_done_o   = (r_state == DONE);
  assign frame_count_o  = r_frame_count;
  assign overrun_o      = r_overrun;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_frame_drain_reader.sv
// Directed + randomized bench for frame_drain_reader: beats, sums and peaks checked against a queue/arithmetic model.
module tb_frame_drain_reader;
  localparam int WIDTH     = 32;
  localparam int DEPTH     = 16;
  localparam int ACC_WIDTH = 36;

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b1;
  logic                        buffer_ready_i = 1'b0;
  logic                        buffer_overflow_i = 1'b0;
  logic signed [ACC_WIDTH-1:0] frame_sum_o;
  logic [WIDTH-1:0]            frame_peak_o;
  logic                        frame_done_o;
  logic [15:0]                 frame_count_o;
  logic                        overrun_o;
  logic                        overflow_o;

  frame_drain_reader_if #(.WIDTH(WIDTH)) bus ();

  frame_drain_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .buffer_ready_i    (buffer_ready_i),
    .buffer_overflow_i (buffer_overflow_i),
    .bus               (bus),
    .frame_sum_o       (frame_sum_o),
    .frame_peak_o      (frame_peak_o),
    .frame_done_o      (frame_done_o),
    .frame_count_o     (frame_count_o),
    .overrun_o         (overrun_o),
    .overflow_o        (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  logic [15:0] exp_count = 16'd0;
  bit          rmode = 1'b0;
  logic [32:0] got[$];
  logic [31:0] smp[DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  // Downstream sink: always ready, or a random ready pattern.
  initial begin
    bus.m_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      bus.m_ready_i = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.m_valid_o && bus.m_ready_i) got.push_back({bus.m_last_o, bus.m_data_o});
      if (frame_done_o) done_cnt++;
      if (bus.m_valid_o && !bus.m_ready_i) chk("rd_ready_backpressure", bus.rd_ready_o, 0);
    end
  end

  task automatic model(output longint s, output longint p);
    longint v;
    longint a;
    s = 0;
    p = 0;
    for (int j = 0; j < DEPTH; j++) begin
      v = longint'($signed(smp[j]));
      s += v;
      a = (v < 0) ? -v : v;
      if (a > p) p = a;
    end
  endtask

  task automatic check_frame(input string tag);
    longint es, ep, os;
    model(es, ep);
    chk({tag, "_beats"}, got.size(), DEPTH);
    for (int j = 0; j < DEPTH && j < got.size(); j++) begin
      chk({tag, "_data"}, got[j][31:0], smp[j]);
      chk({tag, "_last"}, got[j][32], (j == DEPTH - 1));
    end
    os = frame_sum_o;
    chk({tag, "_sum"}, os, es);
    chk({tag, "_peak"}, frame_peak_o, ep);
    got.delete();
  endtask

  task automatic chk_zero(input string tag);
    longint os;
    os = frame_sum_o;
    chk({tag, "_rd_ready"}, bus.rd_ready_o, 0);
    chk({tag, "_m_valid"}, bus.m_valid_o, 0);
    chk({tag, "_m_last"}, bus.m_last_o, 0);
    chk({tag, "_m_data"}, bus.m_data_o, 0);
    chk({tag, "_sum"}, os, 0);
    chk({tag, "_peak"}, frame_peak_o, 0);
    chk({tag, "_done"}, frame_done_o, 0);
    chk({tag, "_count"}, frame_count_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
    chk({tag, "_overflow"}, overflow_o, 0);
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic drive_frame(input bit pulse, input bit gap, input int ov_at, input int of_at, input int abort_at);
    int i = 0;
    int g = 0;
    bit ovf = 1'b0;
    bit off = 1'b0;
    bit acc;
    if (pulse) begin
      buffer_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      buffer_ready_i = 1'b0;
    end
    while (i < DEPTH && i != abort_at && g < 1000) begin
      bus.rd_valid_i    = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.rd_data_i     = smp[i];
      buffer_ready_i    = (i == ov_at) && !ovf;
      if (buffer_ready_i) ovf = 1'b1;
      buffer_overflow_i = (i == of_at) && !off;
      if (buffer_overflow_i) off = 1'b1;
      @(negedge clk_i);
      acc = bus.rd_valid_i && bus.rd_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) i++;
      g++;
    end
    bus.rd_valid_i    = 1'b0;
    buffer_ready_i    = 1'b0;
    buffer_overflow_i = 1'b0;
    chk("drive_timeout", (g < 1000), 1);
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (done_cnt < target && g < 2000) begin
      @(negedge clk_i);
      #1;
      g++;
    end
    chk("done_timeout", (done_cnt >= target), 1);
  endtask

  task automatic finish_frame(input string tag);
    exp_done++;
    exp_count++;
    wait_done(exp_done);
    repeat (3) @(negedge clk_i);
    #1;
    chk({tag, "_done_once"}, done_cnt, exp_done);
    check_frame(tag);
    chk({tag, "_count"}, frame_count_o, exp_count);
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_frame();
    for (int j = 0; j < DEPTH; j++) smp[j] = $urandom;
  endtask

  initial begin
    int g;
    bus.rd_valid_i = 1'b0;
    bus.rd_data_i  = '0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_zero("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_rd_ready", bus.rd_ready_o, 0);
    @(posedge clk_i);
    #1;

    // Ramp 1..16 with a free-running sink
    for (int j = 0; j < DEPTH; j++) smp[j] = 32'(j + 1);
    rmode = 1'b0;
    drive_frame(1'b1, 1'b0, -1, -1, -1);
    finish_frame("ramp");
    chk("ramp_sum_lit", frame_sum_o, 136);
    chk("ramp_peak_lit", frame_peak_o, 16);

    // Same ramp with producer gaps and a stalling sink
    rmode = 1'b1;
    drive_frame(1'b1, 1'b1, -1, -1, -1);
    finish_frame("ramp_bp");

    // Most negative sample then +5s
    smp[0] = 32'h8000_0000;
    for (int j = 1; j < DEPTH; j++) smp[j] = 32'd5;
    drive_frame(1'b1, 1'b1, -1, -1, -1);
    finish_frame("minval");
    chk("minval_peak_lit", frame_peak_o, 32'h8000_0000);

    for (int j = 0; j < DEPTH; j++) smp[j] = 32'hFFFF_FFFF;
    drive_frame(1'b1, 1'b1, -1, -1, -1);
    finish_frame("all_neg1");
    chk("all_neg1_sum_lit", frame_sum_o, -16);

    // Random frames; the second raises a producer overflow mid-frame
    for (int k = 0; k < 3; k++) begin
      rand_frame();
      drive_frame(1'b1, 1'b1, -1, (k == 1) ? 3 : -1, -1);
      finish_frame("rand");
      chk("rand_overflow", overflow_o, (k >= 1));
      chk("rand_overrun", overrun_o, 0);
    end

    // Back-to-back start requested during the DONE cycle
    rand_frame();
    drive_frame(1'b1, 1'b1, -1, -1, -1);
    g = 0;
    while (!frame_done_o && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    chk("b2b_done_seen", frame_done_o, 1);
    buffer_ready_i = 1'b1;
    exp_done++;
    exp_count++;
    check_frame("b2b_a");
    @(posedge clk_i);
    #1;
    buffer_ready_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_drain_next", bus.rd_ready_o, 1);
    @(posedge clk_i);
    #1;
    rand_frame();
    drive_frame(1'b0, 1'b1, -1, -1, -1);
    finish_frame("b2b_b");
    chk("b2b_overrun", overrun_o, 0);

    // Start request at sample 8 of a running frame
    rand_frame();
    drive_frame(1'b1, 1'b1, 8, -1, -1);
    finish_frame("overrun");
    chk("overrun_set", overrun_o, 1);
    repeat (5) @(negedge clk_i);
    #1;
    chk("overrun_sticky", overrun_o, 1);
    chk("overrun_not_queued", bus.rd_ready_o, 0);
    chk("overrun_no_extra_done", done_cnt, exp_done);
    @(posedge clk_i);
    #1;

    // Reset in the middle of a frame
    rand_frame();
    drive_frame(1'b1, 1'b1, -1, -1, 7);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_zero("midreset");
    repeat (20) @(negedge clk_i);
    #1;
    chk("midreset_no_done", done_cnt, exp_done);
    chk("midreset_count", frame_count_o, 0);
    got.delete();
    exp_count = 16'd0;
    @(posedge clk_i);
    #1;
    rand_frame();
    drive_frame(1'b1, 1'b1, -1, -1, -1);
    finish_frame("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
    $fatal(1, "watchdog");
  end
endmodule
